// File: rtl/sm4_key_exp.sv
// sm4_key_exp: iterative SM4 key expansion feeding the 32-stage datapath.
//
// A 128-bit user key is whitened with FK. One round key is produced per
// enabled cycle, so 32 cycles fill the round-key bank. The bank order is
// fixed when the key is loaded: encrypt keeps rk_i in slot i, and decrypt
// puts rk_i in slot 31-i. As a result, the consumer never needs to know the mode.
//
// Ports:
//   clk               rising-edge clock
//   reset             asynchronous, active-high reset
//   sm4_enable_in     global enable; when low, the FSM, counter and registers hold
//   key_valid_in      single-cycle strobe qualifying key_in / decrypt_in
//   key_in[127:0]     user key MK0..MK3, with MK0 at [127:96]
//   decrypt_in        0 = forward slot order, 1 = reversed slot order
//   key_clear_in      (SM4_KEY_ZEROIZE_EN only) wipe the key material, back to IDLE
//   busy_out          expansion in progress
//   key_exp_ready_out all 32 round keys valid and stable
//   rk_out[1023:0]    round-key bank; slot s is at [32*s+31:32*s]
//
// Build option: define SM4_KEY_ZEROIZE_EN to add the key_clear_in zeroize port.

module sm4_key_exp #(
  parameter int NUM_ROUNDS = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sm4_enable_in,
  input  logic                    key_valid_in,
  input  logic [127:0]            key_in,
  input  logic                    decrypt_in,
`ifdef SM4_KEY_ZEROIZE_EN
  input  logic                    key_clear_in,
`endif
  output logic                    busy_out,
  output logic                    key_exp_ready_out,
  output logic [32*NUM_ROUNDS-1:0] rk_out
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXPAND = 2'd1, DONE = 2'd2} state_t;

  localparam logic [127:0] FK = 128'ha3b1bac6_56aa3350_677d9197_b27022dc;

  localparam logic [7:0] SBOX [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  state_t                    state_q, state_d;
  logic [4:0]                cnt_q, cnt_d;
  logic [127:0]              key_q, key_d;   // {K0,K1,K2,K3}, K0 at [127:96]
  logic                      dec_q, dec_d;
  logic [32*NUM_ROUNDS-1:0]  bank_q, bank_d;

  logic [7:0]  ck_base;
  logic [31:0] ck, round_in, tau_out, rk_new;
  logic [4:0]  slot;

  // The constant CK_i is derived from the counter instead of being stored in a table.
  // Byte j is (4i+j)*7 mod 256, and the 8-bit truncation does the mod.
  always_comb begin
    ck_base  = {1'b0, cnt_q, 2'b00};
    ck       = {8'(ck_base * 8'd7),
                8'((ck_base + 8'd1) * 8'd7),
                8'((ck_base + 8'd2) * 8'd7),
                8'((ck_base + 8'd3) * 8'd7)};
    round_in = key_q[95:64] ^ key_q[63:32] ^ key_q[31:0] ^ ck;
    tau_out  = {SBOX[round_in[31:24]], SBOX[round_in[23:16]],
                SBOX[round_in[15:8]],  SBOX[round_in[7:0]]};
    rk_new   = key_q[127:96] ^ tau_out ^ {tau_out[18:0], tau_out[31:19]}
                                       ^ {tau_out[8:0],  tau_out[31:9]};
    // In decrypt order, 31-i is the bitwise inverse of a 5-bit i.
    slot     = dec_q ? ~cnt_q : cnt_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      key_q   <= '0;
      dec_q   <= 1'b0;
      bank_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      dec_q   <= dec_d;
      bank_q  <= bank_d;
    end
  end

  // Next-state logic. A new key can start from IDLE or DONE.
  // A key strobe during EXPAND does not restart the expansion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (sm4_enable_in && key_valid_in) state_d = EXPAND;
      EXPAND:     if (sm4_enable_in && cnt_q == 5'd31) state_d = DONE;
      default:    state_d = IDLE;
    endcase
`ifdef SM4_KEY_ZEROIZE_EN
    if (key_clear_in) state_d = IDLE;
`endif
  end

  // Datapath. Key load and round advance happen only on enabled cycles.
  // Zeroize wins over both and ignores the enable.
  always_comb begin
    key_d  = key_q;
    cnt_d  = cnt_q;
    dec_d  = dec_q;
    bank_d = bank_q;
    if (sm4_enable_in) begin
      if ((state_q == IDLE || state_q == DONE) && key_valid_in) begin
        key_d = key_in ^ FK;
        cnt_d = '0;
        dec_d = decrypt_in;
      end else if (state_q == EXPAND) begin
        key_d = {key_q[95:0], rk_new};
        cnt_d = cnt_q + 5'd1;
        bank_d[{slot, 5'b00000} +: 32] = rk_new;
      end
    end
`ifdef SM4_KEY_ZEROIZE_EN
    if (key_clear_in) begin
      key_d  = '0;
      cnt_d  = '0;
      bank_d = '0;
    end
`endif
  end

  // Outputs
  always_comb begin
    busy_out          = (state_q == EXPAND);
    key_exp_ready_out = (state_q == DONE);
    rk_out            = bank_q;
  end

endmodule

// File: doc/sm4_key_exp.md
Name: sm4_key_exp

Overview:
- Iterative SM4 key-expansion stage, directly upstream of the 32-stage pipelined encrypt/decrypt datapath.
- Accepts a 128-bit user key and computes one round key per cycle, 32 cycles total.
- Holds all 32 round keys in a register bank and raises key_exp_ready_out for the consumer.
- Round-key order is chosen at key load: forward for encrypt, reversed for decrypt, so the consumer is mode-agnostic.

Parameters:
- NUM_ROUNDS, 32, number of round keys. Fixed by SM4; only 32 is supported.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- sm4_enable_in  input  1  global enable. When low, FSM, counter and registers hold.
- key_valid_in  input  1  single-cycle strobe; key_in and decrypt_in are valid.
- key_in  input  128  user key MK0..MK3, MK0 at [127:96].
- decrypt_in  input  1  0 = encrypt order, 1 = decrypt order. Sampled with key_valid_in.
- busy_out  output  1  expansion in progress.
- key_exp_ready_out  output  1  all 32 round keys valid and stable.
- rk_out  output  1024  round-key bank. Slot s occupies [32*s+31:32*s]. Integration slices slot s onto rk_<ss>_in of the datapath.

Behaviour:
- Reset: busy_out=0, key_exp_ready_out=0, rk_out=0, FSM=IDLE, round counter=0, K0..K3=0.
- FSM states:
  - IDLE: key_valid_in && sm4_enable_in -> EXPAND. Latch K0..K3 = MK ^ FK (FK = a3b1bac6,56aa3350,677d9197,b27022dc), latch decrypt_in, counter=0.
  - EXPAND: each enabled cycle computes rk_i = K0 ^ T'(K1^K2^K3^CK_i), with T'(x) = L'(tau(x)) and L'(B) = B ^ (B<<<13) ^ (B<<<23).
    - Shift {K0,K1,K2,K3} <= {K1,K2,K3,rk_i}.
    - Write rk_i into slot i (encrypt) or slot 31-i (decrypt). Counter++.
    - When counter==31 -> DONE.
  - DONE: key_exp_ready_out=1. key_valid_in && sm4_enable_in -> EXPAND with the new key; ready drops on that same edge.
- tau: four parallel byte lookups in the standard SM4 S-box (GB/T 32907).
- CK_i generated arithmetically, not from a table: byte j of CK_i = ((4*i+j)*7) mod 256, byte 0 at [31:24]. Counter is 5 bits.
- Latency: key accepted on edge E. rk_0 written on E+1, rk_31 on E+32. key_exp_ready_out and busy_out=0 take effect on E+32.
- busy_out=1 from edge E to E+32.
- key_valid_in during EXPAND is ignored; no restart, no error.
- sm4_enable_in low mid-EXPAND: stall, no counter advance, no bank write. Resume exactly where it stopped.
- rk_out slots not yet rewritten keep old values during re-expansion; consumers must gate on key_exp_ready_out.
- Reset asserted mid-operation clears everything immediately, including the bank and FSM.

Optional Feature:
- Macro SM4_KEY_ZEROIZE_EN.
- Defined: adds input key_clear_in (1 bit). When high, on the next edge: bank, K0..K3 and counter go to 0, FSM -> IDLE, ready and busy -> 0.
  - Priority: reset > key_clear_in > key_valid_in.
  - key_clear_in acts regardless of sm4_enable_in.
- Undefined: no port and no zeroize logic; round keys persist until overwritten or reset.

Test Plan:
- Reset, key_in=0123456789abcdeffedcba9876543210, decrypt_in=0, one-cycle key_valid_in -> ready rises exactly 32 edges later. Slot0=f12186f9, slot1=41662b61, slot31=9124a012.
- Same key, decrypt_in=1 -> slot0=9124a012, slot31=f12186f9, ready latency 32.
- Hold sm4_enable_in low for 5 cycles at round 10 -> ready latency 37, slots identical to the first scenario.
- Pulse key_valid_in with a different key at round 20 -> ignored; final slots match the first key.
- In DONE, load key 0 -> ready low on the next edge, high 32 edges later. Assert reset mid-expansion -> all outputs 0 immediately.
- With SM4_KEY_ZEROIZE_EN: after DONE, pulse key_clear_in -> rk_out=0 and ready=0 next edge. Pulse it together with key_valid_in -> clear wins, FSM stays IDLE.
